// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: key map, FSM state, candidate encoding.
package keypad_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_t;

  // Scan candidate: {none_flag, code}; none_flag set means no key seen.
  typedef logic [4:0] cand_t;
  localparam cand_t CAND_NONE = 5'b1_0000;

  // Indexed by {row, col}; element 0 is row 0 / col 0.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    return KEY_MAP[{r, c}];
  endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// Debounces per-scan candidates and commits one key event per press; keeps the 4-digit history.
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_end,
  input  cand_t       candidate,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] digits
);

  localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_SCANS);

  logic [3:0]  stable_cnt_reg;
  logic [3:0]  stable_cnt_next;
  cand_t       prev_cand_reg;
  state_t      state_reg;
  logic [3:0]  key_code_reg;
  logic        key_valid_reg;
  logic        key_held_reg;
  logic [15:0] digits_reg;
  logic        stable;

  // Count saturates so a long hold never wraps back into a fresh press.
  always_comb begin
    stable_cnt_next = 4'd1;
    if (candidate == prev_cand_reg) begin
      stable_cnt_next = (stable_cnt_reg == STABLE_MAX) ? stable_cnt_reg : stable_cnt_reg + 4'd1;
    end
  end

  assign stable = (stable_cnt_next == STABLE_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_cnt_reg <= 4'd0;
      prev_cand_reg  <= CAND_NONE;
      state_reg      <= IDLE;
      key_code_reg   <= 4'd0;
      key_valid_reg  <= 1'b0;
      key_held_reg   <= 1'b0;
      digits_reg     <= 16'd0;
    end else begin
      key_valid_reg <= 1'b0;
      if (scan_end) begin
        stable_cnt_reg <= stable_cnt_next;
        prev_cand_reg  <= candidate;
        case (state_reg)
          IDLE: begin
            if (stable && !candidate[4]) begin
              state_reg     <= PRESSED;
              key_code_reg  <= candidate[3:0];
              digits_reg    <= {digits_reg[11:0], candidate[3:0]};
              key_valid_reg <= 1'b1;
              key_held_reg  <= 1'b1;
            end
          end
          PRESSED: begin
            // A different stable key is ignored; only a stable release re-arms.
            if (stable && candidate[4]) begin
              state_reg    <= IDLE;
              key_held_reg <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;
  assign digits    = digits_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, synchronized row sampling, per-scan accumulation.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 20000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] digits
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    row_meta_reg;
  logic [3:0]    row_sync_reg;
  logic [DW-1:0] dwell_reg;
  logic [1:0]    col_idx_reg;
  logic [3:0]    col_reg;
  cand_t         acc_reg;
  cand_t         col_hit;
  cand_t         candidate;
  logic          sample;
  logic          scan_end;

  assign sample   = (dwell_reg == DWELL_LAST);
  assign scan_end = sample && (col_idx_reg == 2'd3);

  // Lowest pressed row in the current column wins.
  always_comb begin
    col_hit = CAND_NONE;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync_reg[r]) begin
        col_hit = {1'b0, key_lookup(2'(r), col_idx_reg)};
      end
    end
  end

  // Columns are visited in ascending order, so the first hit held is the lowest column.
  assign candidate = acc_reg[4] ? col_hit : acc_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
      dwell_reg    <= '0;
      col_idx_reg  <= 2'd0;
      col_reg      <= 4'b1110;
      acc_reg      <= CAND_NONE;
    end else begin
      row_meta_reg <= row;
      row_sync_reg <= row_meta_reg;
      if (sample) begin
        dwell_reg   <= '0;
        col_idx_reg <= col_idx_reg + 2'd1;
        col_reg     <= ~(4'b0001 << (col_idx_reg + 2'd1));
        acc_reg     <= scan_end ? CAND_NONE : candidate;
      end else begin
        dwell_reg <= dwell_reg + 1'b1;
      end
    end
  end

  assign col = col_reg;

  keypad_debouncer #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debouncer (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_end (scan_end),
    .candidate(candidate),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .digits   (digits)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2 (one scan = 16 cycles).
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] digits;

  logic [15:0] mask = 16'h0000;   // pressed keys, bit index = row*4 + col
  int total = 0;
  int bad = 0;
  int pulses = 0;

  typedef struct {
    logic [15:0] mask;
    int          scans;
    int          pulses;
    logic [3:0]  code;
    logic [15:0] digits;
    logic        held;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .digits   (digits)
  );

  // Keypad matrix model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && mask[r*4+c]) row[r] = 1'b0;
  end

  // Counted on posedge so the count is settled when read at negedge.
  always @(posedge clk) if (rst_n && key_valid) pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " col"}, 32'(col), 32'h0000000E);
    check({tag, " key_code"}, 32'(key_code), 32'h0);
    check({tag, " key_valid"}, 32'(key_valid), 32'h0);
    check({tag, " key_held"}, 32'(key_held), 32'h0);
    check({tag, " digits"}, 32'(digits), 32'h0);
  endtask

  initial begin
    int base;
    logic [3:0] exp_col;

    vecs[0]  = '{16'h0040, 5, 1, 4'h6, 16'h0006, 1'b1};
    vecs[1]  = '{16'h0000, 1, 0, 4'h6, 16'h0006, 1'b1};
    vecs[2]  = '{16'h0000, 1, 0, 4'h6, 16'h0006, 1'b0};
    vecs[3]  = '{16'h0001, 4, 1, 4'h1, 16'h0061, 1'b1};
    vecs[4]  = '{16'h0000, 3, 0, 4'h1, 16'h0061, 1'b0};
    vecs[5]  = '{16'h0020, 4, 1, 4'h5, 16'h0615, 1'b1};
    vecs[6]  = '{16'h0000, 3, 0, 4'h5, 16'h0615, 1'b0};
    vecs[7]  = '{16'h0400, 4, 1, 4'h9, 16'h6159, 1'b1};
    vecs[8]  = '{16'h0000, 3, 0, 4'h9, 16'h6159, 1'b0};
    vecs[9]  = '{16'h8000, 4, 1, 4'hD, 16'h159D, 1'b1};
    vecs[10] = '{16'h0000, 3, 0, 4'hD, 16'h159D, 1'b0};
    vecs[11] = '{16'h8200, 4, 1, 4'h8, 16'h59D8, 1'b1};
    vecs[12] = '{16'h8000, 4, 0, 4'h8, 16'h59D8, 1'b1};
    vecs[13] = '{16'h0000, 3, 0, 4'h8, 16'h59D8, 1'b0};

    // Reset state
    rst_n = 1'b0;
    mask  = 16'h0000;
    run_cycles(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Idle scanning: column sequence and no events
    for (int k = 0; k < 16; k++) begin
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check($sformatf("col k=%0d", k), 32'(col), 32'(exp_col));
      run_cycles(1);
    end
    run_cycles(16 * 9);
    check("idle pulses", 32'(pulses), 32'h0);
    check("idle digits", 32'(digits), 32'h0);
    check("idle held", 32'(key_held), 32'h0);

    // Table-driven press/release phases, each aligned to scan boundaries
    for (int i = 0; i < 14; i++) begin
      base = pulses;
      mask = vecs[i].mask;
      run_cycles(16 * vecs[i].scans);
      check($sformatf("vec%0d pulses", i), 32'(pulses - base), 32'(vecs[i].pulses));
      check($sformatf("vec%0d code", i), 32'(key_code), 32'(vecs[i].code));
      check($sformatf("vec%0d digits", i), 32'(digits), 32'(vecs[i].digits));
      check($sformatf("vec%0d held", i), 32'(key_held), 32'(vecs[i].held));
    end

    // Bounce on key 1, then steady hold: pulse exactly after the 2nd stable scan end
    base = pulses;
    for (int s = 0; s < 6; s++) begin
      mask = (s % 2 == 0) ? 16'h0001 : 16'h0000;
      run_cycles(16);
    end
    check("bounce pulses", 32'(pulses - base), 32'h0);
    mask = 16'h0001;
    run_cycles(31);
    check("steady valid early", 32'(key_valid), 32'h0);
    run_cycles(1);
    check("steady valid", 32'(key_valid), 32'h1);
    check("steady code", 32'(key_code), 32'h1);
    check("steady held", 32'(key_held), 32'h1);
    run_cycles(1);
    check("steady valid one cycle", 32'(key_valid), 32'h0);
    run_cycles(15);
    mask = 16'h0000;
    run_cycles(32);
    check("steady release held", 32'(key_held), 32'h0);
    check("steady digits", 32'(digits), 32'h9D81);
    check("steady pulses", 32'(pulses - base), 32'h1);

    // Hold A, reset mid-scan while pressed, re-debounce after release
    mask = 16'h0008;
    run_cycles(48);
    check("pre-reset code", 32'(key_code), 32'hA);
    check("pre-reset digits", 32'(digits), 32'hD81A);
    check("pre-reset held", 32'(key_held), 32'h1);
    run_cycles(5);
    rst_n = 1'b0;
    for (int j = 0; j < 3; j++) begin
      run_cycles(1);
      check_reset_outputs($sformatf("midreset%0d", j));
    end
    rst_n = 1'b1;
    base = pulses;
    run_cycles(31);
    check("post-reset early valid", 32'(key_valid), 32'h0);
    check("post-reset early pulses", 32'(pulses - base), 32'h0);
    run_cycles(1);
    check("post-reset valid", 32'(key_valid), 32'h1);
    check("post-reset code", 32'(key_code), 32'hA);
    check("post-reset digits", 32'(digits), 32'h000A);
    check("post-reset held", 32'(key_held), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
